mv_uart_gen2: RTL



---
 rtl/mv_uart_gen2.sv | 282 ++++++++++++++++++++++++++++
 1 files changed

// File: rtl/mv_uart_gen2.sv
// Parametrised full-duplex UART: synchronous TX FIFO, LSB-first framing, RX with 2-flop sync,
// false-start rejection and framing errors. Parity is compiled in with `define MV_UART_PARITY_EN.
`timescale 1ns/1ps
module mv_uart_gen2 #(
  parameter int CLKS_PER_BIT = 16,
  parameter int DATA_BITS    = 8,
  parameter int STOP_BITS    = 1,
  parameter int TX_DEPTH     = 4,
  parameter int PARITY_ODD   = 0
) (
  input  logic                        clock,
  input  logic                        reset,
  input  logic [DATA_BITS-1:0]        tx_data,
  input  logic                        tx_req,
  output logic                        tx_ready,
  output logic                        tx_drop,
  output logic                        tx_busy,
  output logic [$clog2(TX_DEPTH):0]   tx_level,
  output logic [DATA_BITS-1:0]        rx_data,
  output logic                        rx_strobe,
  output logic                        rx_frame_err,
  output logic                        rx_parity_err,
  output logic                        txd,
  input  logic                        rxd
);
  localparam int AW = $clog2(TX_DEPTH);
  localparam int CW = $clog2(2*CLKS_PER_BIT);
  localparam int BW = $clog2(DATA_BITS);
  localparam logic [CW-1:0] BIT_END  = CW'(CLKS_PER_BIT-1);
  localparam logic [CW-1:0] STOP_END = CW'(STOP_BITS*CLKS_PER_BIT-1);
  localparam logic [CW-1:0] HALF     = CW'(CLKS_PER_BIT/2);
  localparam logic [BW-1:0] LAST_BIT = BW'(DATA_BITS-1);
`ifdef MV_UART_PARITY_EN
  localparam logic PAR_ODD = (PARITY_ODD != 0);
`endif

  typedef enum logic [2:0] {
    T_IDLE, T_START, T_DATA,
`ifdef MV_UART_PARITY_EN
    T_PARITY,
`endif
    T_STOP
  } tx_state_t;

  typedef enum logic [2:0] {
    R_IDLE, R_START, R_DATA,
`ifdef MV_UART_PARITY_EN
    R_PARITY,
`endif
    R_STOP, R_BREAK
  } rx_state_t;

  // ---------------- TX FIFO ----------------
  logic [DATA_BITS-1:0] fifo_mem [TX_DEPTH];
  logic [AW-1:0]        wr_ptr, rd_ptr;
  logic [AW:0]          fifo_cnt;
  logic                 full, empty, push, pop;

  assign full     = (fifo_cnt == (AW+1)'(TX_DEPTH));
  assign empty    = (fifo_cnt == '0);
  assign push     = tx_req & ~full;
  assign tx_ready = ~full;
  assign tx_level = fifo_cnt;

  always_ff @(posedge clock) begin
    if (reset) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      fifo_cnt <= '0;
      tx_drop  <= 1'b0;
    end else begin
      if (push) begin
        fifo_mem[wr_ptr] <= tx_data;
        wr_ptr <= wr_ptr + 1'b1;
      end
      if (pop) rd_ptr <= rd_ptr + 1'b1;
      fifo_cnt <= fifo_cnt + (AW+1)'(push) - (AW+1)'(pop);
      // a full FIFO rejects even if the FSM pops in the same cycle
      tx_drop  <= tx_req & full;
    end
  end

  // ---------------- TX FSM ----------------
  tx_state_t            tx_st, tx_st_d;
  logic [CW-1:0]        tx_cnt, tx_cnt_d;
  logic [BW-1:0]        tx_bit, tx_bit_d;
  logic [DATA_BITS-1:0] tx_sh, tx_sh_d;
  logic                 txd_d;
`ifdef MV_UART_PARITY_EN
  logic                 tx_par, tx_par_d;
`endif

  always_ff @(posedge clock) begin
    if (reset) begin
      tx_st  <= T_IDLE;
      tx_cnt <= '0;
      tx_bit <= '0;
      tx_sh  <= '0;
      txd    <= 1'b1;
`ifdef MV_UART_PARITY_EN
      tx_par <= 1'b0;
`endif
    end else begin
      tx_st  <= tx_st_d;
      tx_cnt <= tx_cnt_d;
      tx_bit <= tx_bit_d;
      tx_sh  <= tx_sh_d;
      txd    <= txd_d;
`ifdef MV_UART_PARITY_EN
      tx_par <= tx_par_d;
`endif
    end
  end

  always_comb begin
    tx_st_d  = tx_st;
    tx_cnt_d = tx_cnt + 1'b1;
    tx_bit_d = tx_bit;
    tx_sh_d  = tx_sh;
    txd_d    = txd;
    pop      = 1'b0;
`ifdef MV_UART_PARITY_EN
    tx_par_d = tx_par;
`endif
    case (tx_st)
      T_IDLE: begin
        tx_cnt_d = '0;
        txd_d    = 1'b1;
        if (!empty) begin
          pop = 1'b1; txd_d = 1'b0; tx_st_d = T_START;
        end
      end
      T_START: if (tx_cnt == BIT_END) begin
        tx_cnt_d = '0; tx_bit_d = '0; txd_d = tx_sh[0]; tx_st_d = T_DATA;
      end
      T_DATA: if (tx_cnt == BIT_END) begin
        tx_cnt_d = '0;
        if (tx_bit == LAST_BIT) begin
`ifdef MV_UART_PARITY_EN
          txd_d = tx_par; tx_st_d = T_PARITY;
`else
          txd_d = 1'b1; tx_st_d = T_STOP;
`endif
        end else begin
          tx_bit_d = tx_bit + 1'b1;
          tx_sh_d  = tx_sh >> 1;
          txd_d    = tx_sh[1];
        end
      end
`ifdef MV_UART_PARITY_EN
      T_PARITY: if (tx_cnt == BIT_END) begin
        tx_cnt_d = '0; txd_d = 1'b1; tx_st_d = T_STOP;
      end
`endif
      T_STOP: if (tx_cnt == STOP_END) begin
        tx_cnt_d = '0;
        // back-to-back: next start bit follows the stop bit with no idle gap
        if (!empty) begin
          pop = 1'b1; txd_d = 1'b0; tx_st_d = T_START;
        end else begin
          txd_d = 1'b1; tx_st_d = T_IDLE;
        end
      end
      default: tx_st_d = T_IDLE;
    endcase
    if (pop) begin
      tx_sh_d = fifo_mem[rd_ptr];
`ifdef MV_UART_PARITY_EN
      tx_par_d = (^fifo_mem[rd_ptr]) ^ PAR_ODD;
`endif
    end
  end

  assign tx_busy = (tx_st != T_IDLE) | ~empty;

  // ---------------- RX ----------------
  logic                 rx_s1, rx_s2;
  rx_state_t            rx_st, rx_st_d;
  logic [CW-1:0]        rx_cnt, rx_cnt_d;
  logic [BW-1:0]        rx_bit, rx_bit_d;
  logic [DATA_BITS-1:0] rx_sh, rx_sh_d, rx_data_d;
  logic                 rx_strobe_d, rx_ferr_d;
`ifdef MV_UART_PARITY_EN
  logic                 rx_pbit, rx_pbit_d, rx_perr_d;
`endif

  always_ff @(posedge clock) begin
    if (reset) begin
      rx_s1        <= 1'b1;
      rx_s2        <= 1'b1;
      rx_st        <= R_IDLE;
      rx_cnt       <= '0;
      rx_bit       <= '0;
      rx_sh        <= '0;
      rx_data      <= '0;
      rx_strobe    <= 1'b0;
      rx_frame_err <= 1'b0;
`ifdef MV_UART_PARITY_EN
      rx_pbit       <= 1'b0;
      rx_parity_err <= 1'b0;
`endif
    end else begin
      rx_s1        <= rxd;
      rx_s2        <= rx_s1;
      rx_st        <= rx_st_d;
      rx_cnt       <= rx_cnt_d;
      rx_bit       <= rx_bit_d;
      rx_sh        <= rx_sh_d;
      rx_data      <= rx_data_d;
      rx_strobe    <= rx_strobe_d;
      rx_frame_err <= rx_ferr_d;
`ifdef MV_UART_PARITY_EN
      rx_pbit       <= rx_pbit_d;
      rx_parity_err <= rx_perr_d;
`endif
    end
  end

  always_comb begin
    rx_st_d     = rx_st;
    rx_cnt_d    = rx_cnt + 1'b1;
    rx_bit_d    = rx_bit;
    rx_sh_d     = rx_sh;
    rx_data_d   = rx_data;
    rx_strobe_d = 1'b0;
    rx_ferr_d   = 1'b0;
`ifdef MV_UART_PARITY_EN
    rx_pbit_d   = rx_pbit;
    rx_perr_d   = 1'b0;
`endif
    case (rx_st)
      R_IDLE: begin
        rx_cnt_d = '0;
        if (!rx_s2) rx_st_d = R_START;
      end
      // re-check at mid start bit; a high line here was a glitch
      R_START: if (rx_cnt == HALF) begin
        rx_cnt_d = '0; rx_bit_d = '0;
        rx_st_d  = rx_s2 ? R_IDLE : R_DATA;
      end
      R_DATA: if (rx_cnt == BIT_END) begin
        rx_cnt_d = '0;
        rx_sh_d  = {rx_s2, rx_sh[DATA_BITS-1:1]};
        if (rx_bit == LAST_BIT) begin
`ifdef MV_UART_PARITY_EN
          rx_st_d = R_PARITY;
`else
          rx_st_d = R_STOP;
`endif
        end else begin
          rx_bit_d = rx_bit + 1'b1;
        end
      end
`ifdef MV_UART_PARITY_EN
      R_PARITY: if (rx_cnt == BIT_END) begin
        rx_cnt_d = '0; rx_pbit_d = rx_s2; rx_st_d = R_STOP;
      end
`endif
      R_STOP: if (rx_cnt == BIT_END) begin
        rx_cnt_d = '0;
        if (rx_s2) begin
          rx_data_d   = rx_sh;
          rx_strobe_d = 1'b1;
`ifdef MV_UART_PARITY_EN
          rx_perr_d   = rx_pbit ^ (^rx_sh) ^ PAR_ODD;
`endif
          rx_st_d     = R_IDLE;
        end else begin
          rx_ferr_d = 1'b1;
          rx_st_d   = R_BREAK;
        end
      end
      R_BREAK: if (rx_s2) rx_st_d = R_IDLE;
      default: rx_st_d = R_IDLE;
    endcase
  end

`ifndef MV_UART_PARITY_EN
  assign rx_parity_err = 1'b0;
`endif

endmodule
